// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon message padder: state encoding,
// the padding byte and the rate-to-bytes helper.
package ascon_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_OUT  = 1'b1
    } pad_state_e;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Number of whole bytes in a rate of the given bit width.
    function automatic int rate_bytes(input int rate);
        return rate / 8;
    endfunction

endpackage

// File: rtl/ascon_msg_padder.sv
// Ascon message padder: packs a byte stream big-endian into RATE-bit
// blocks and applies 0x80 / zero-fill padding. A message whose length is a
// multiple of the block size is followed by an extra pad-only last block.
// Optional build macro ASCON_MSG_LEN_EN adds the msg_lenxSO byte counter.
module ascon_msg_padder
    import ascon_pkg::*;
#(
    parameter  int RATE       = 64,
    localparam int RATE_BYTES = rate_bytes(RATE)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            byte_validxSI,
    input  logic [7:0]      byte_dataxSI,
    input  logic            msg_endxSI,
    output logic            byte_readyxSO,
    output logic            blk_validxSO,
    output logic [RATE-1:0] blk_dataxSO,
    output logic            blk_lastxSO,
    input  logic            blk_readyxSI
`ifdef ASCON_MSG_LEN_EN
    ,
    output logic [31:0]     msg_lenxSO
`endif
);

    localparam int CNT_W = (RATE_BYTES > 1) ? $clog2(RATE_BYTES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_BYTES - 1);

    pad_state_e       r_state, w_state;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic [RATE-1:0]  r_data, w_data;
    logic             r_last, w_last;
    logic             r_pad_pend, w_pad_pend;
`ifdef ASCON_MSG_LEN_EN
    logic [31:0]      r_len, w_len;
`endif

    // Write one byte into the given big-endian slot, leaving others as they are.
    function automatic logic [RATE-1:0] put_byte(input logic [RATE-1:0] d,
                                                 input int slot,
                                                 input logic [7:0] b);
        logic [RATE-1:0] r;
        r = d;
        for (int i = 0; i < RATE_BYTES; i++) begin
            r[RATE-1-8*i -: 8] = (i == slot) ? b : r[RATE-1-8*i -: 8];
        end
        return r;
    endfunction

    // Place the pad byte at the slot and zero every slot after it.
    function automatic logic [RATE-1:0] pad_from(input logic [RATE-1:0] d,
                                                 input int slot);
        logic [RATE-1:0] r;
        r = d;
        for (int i = 0; i < RATE_BYTES; i++) begin
            r[RATE-1-8*i -: 8] = (i == slot) ? PAD_BYTE :
                                 ((i > slot) ? 8'h00 : r[RATE-1-8*i -: 8]);
        end
        return r;
    endfunction

    // Next-state logic: byte packing, padding and block hand-off.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_data     = r_data;
        w_last     = r_last;
        w_pad_pend = r_pad_pend;
`ifdef ASCON_MSG_LEN_EN
        w_len      = r_len;
`endif
        case (r_state)
            ST_FILL: begin
`ifdef ASCON_MSG_LEN_EN
                if (byte_validxSI) begin
                    w_len = r_len + 32'd1;
                end else begin
                    w_len = r_len;
                end
`endif
                if (byte_validxSI && msg_endxSI) begin
                    w_data  = put_byte(r_data, int'(r_cnt), byte_dataxSI);
                    w_state = ST_OUT;
                    w_cnt   = '0;
                    if (r_cnt == CNT_LAST) begin
                        // Block is full: the pad goes into a follow-on block.
                        w_last     = 1'b0;
                        w_pad_pend = 1'b1;
                    end else begin
                        w_data = pad_from(w_data, int'(r_cnt) + 1);
                        w_last = 1'b1;
                    end
                end else if (byte_validxSI) begin
                    w_data = put_byte(r_data, int'(r_cnt), byte_dataxSI);
                    if (r_cnt == CNT_LAST) begin
                        w_state = ST_OUT;
                        w_last  = 1'b0;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + CNT_W'(1);
                    end
                end else if (msg_endxSI) begin
                    w_data  = pad_from(r_data, int'(r_cnt));
                    w_state = ST_OUT;
                    w_last  = 1'b1;
                    w_cnt   = '0;
                end else begin
                    w_state = ST_FILL;
                end
            end
            ST_OUT: begin
                if (blk_readyxSI) begin
`ifdef ASCON_MSG_LEN_EN
                    if (r_last) begin
                        w_len = 32'd0;
                    end else begin
                        w_len = r_len;
                    end
`endif
                    if (r_pad_pend) begin
                        w_data     = pad_from('0, 0);
                        w_pad_pend = 1'b0;
                        w_last     = 1'b1;
                    end else begin
                        w_data  = '0;
                        w_last  = 1'b0;
                        w_state = ST_FILL;
                        w_cnt   = '0;
                    end
                end else begin
                    w_state = ST_OUT;
                end
            end
            default: begin
                w_state    = ST_FILL;
                w_cnt      = '0;
                w_data     = '0;
                w_last     = 1'b0;
                w_pad_pend = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_FILL;
            r_cnt      <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
`ifdef ASCON_MSG_LEN_EN
            r_len      <= 32'd0;
`endif
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_data     <= w_data;
            r_last     <= w_last;
            r_pad_pend <= w_pad_pend;
`ifdef ASCON_MSG_LEN_EN
            r_len      <= w_len;
`endif
        end
    end

    assign byte_readyxSO = (r_state == ST_FILL);
    assign blk_validxSO  = (r_state == ST_OUT);
    assign blk_dataxSO   = r_data;
    assign blk_lastxSO   = r_last;
`ifdef ASCON_MSG_LEN_EN
    assign msg_lenxSO    = r_len;
`endif

endmodule

// File: tb/tb_ascon_msg_padder.sv
// Scoreboard bench for ascon_msg_padder at RATE=64.
module tb_ascon_msg_padder;

    logic        clk;
    logic        rst;
    logic        byte_validxSI;
    logic [7:0]  byte_dataxSI;
    logic        msg_endxSI;
    logic        byte_readyxSO;
    logic        blk_validxSO;
    logic [63:0] blk_dataxSO;
    logic        blk_lastxSO;
    logic        blk_readyxSI;
`ifdef ASCON_MSG_LEN_EN
    logic [31:0] msg_lenxSO;
`endif

    typedef struct {
        logic [63:0] d;
        logic        l;
        logic [31:0] n;
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_err;

    ascon_msg_padder #(.RATE(64)) dut (
        .clk           (clk),
        .rst           (rst),
        .byte_validxSI (byte_validxSI),
        .byte_dataxSI  (byte_dataxSI),
        .msg_endxSI    (msg_endxSI),
        .byte_readyxSO (byte_readyxSO),
        .blk_validxSO  (blk_validxSO),
        .blk_dataxSO   (blk_dataxSO),
        .blk_lastxSO   (blk_lastxSO),
        .blk_readyxSI  (blk_readyxSI)
`ifdef ASCON_MSG_LEN_EN
        ,
        .msg_lenxSO    (msg_lenxSO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every block handshake is popped and compared against the queue.
    always @(negedge clk) begin
        if (rst && blk_validxSI_hs()) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_block: got data=%016h last=%0b, expected no block",
                         blk_dataxSO, blk_lastxSO);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (blk_dataxSO !== e.d || blk_lastxSO !== e.l) begin
                    n_err++;
                    $display("FAIL block: got data=%016h last=%0b, expected data=%016h last=%0b",
                             blk_dataxSO, blk_lastxSO, e.d, e.l);
                end
`ifdef ASCON_MSG_LEN_EN
                if (e.l) begin
                    n_vec++;
                    if (msg_lenxSO !== e.n) begin
                        n_err++;
                        $display("FAIL msg_len: got %0d, expected %0d", msg_lenxSO, e.n);
                    end
                end
`endif
            end
        end
    end

    function automatic bit blk_validxSI_hs();
        return blk_validxSO && blk_readyxSI;
    endfunction

    task automatic expect_blk(input logic [63:0] d, input logic l, input logic [31:0] n);
        exp_t e;
        e.d = d; e.l = l; e.n = n;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Present a byte and/or end strobe, hold until accepted (bounded).
    task automatic put(input logic [7:0] b, input logic v, input logic e);
        bit acc;
        byte_validxSI = v;
        byte_dataxSI  = b;
        msg_endxSI    = e;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = byte_readyxSO;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL input_timeout: got no accept, expected accept within 200 cycles");
        end
        byte_validxSI = 1'b0;
        msg_endxSI    = 1'b0;
        byte_dataxSI  = 8'h00;
    endtask

    // Wait for all expected blocks to be delivered, then for FILL.
    task automatic drain();
        int k;
        for (k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending blocks, expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        byte_validxSI = 1'b0;
        byte_dataxSI  = 8'h00;
        msg_endxSI    = 1'b0;
        blk_readyxSI  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_byte_ready", 64'(byte_readyxSO), 64'd1);
        check("rst_blk_valid",  64'(blk_validxSO),  64'd0);
        check("rst_blk_data",   blk_dataxSO,        64'd0);
        check("rst_blk_last",   64'(blk_lastxSO),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Empty message.
        expect_blk(64'h8000000000000000, 1'b1, 32'd0);
        put(8'h00, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        check("empty_ready_back", 64'(byte_readyxSO), 64'd1);
        @(posedge clk);
        #1;

        // Three bytes then end.
        expect_blk(64'h4142438000000000, 1'b1, 32'd3);
        put(8'h41, 1'b1, 1'b0);
        put(8'h42, 1'b1, 1'b0);
        put(8'h43, 1'b1, 1'b0);
        put(8'h00, 1'b0, 1'b1);
        drain();

        // Full block, end on a later cycle.
        expect_blk(64'h0102030405060708, 1'b0, 32'd8);
        expect_blk(64'h8000000000000000, 1'b1, 32'd8);
        for (int i = 1; i <= 8; i++) put(8'(i), 1'b1, 1'b0);
        put(8'h00, 1'b0, 1'b1);
        drain();

        // Full block with end on the last byte (pad_pend path).
        expect_blk(64'h0102030405060708, 1'b0, 32'd8);
        expect_blk(64'h8000000000000000, 1'b1, 32'd8);
        for (int i = 1; i <= 7; i++) put(8'(i), 1'b1, 1'b0);
        put(8'h08, 1'b1, 1'b1);
        drain();

        // Backpressure on a full block while an end strobe waits.
        expect_blk(64'h1112131415161718, 1'b0, 32'd8);
        expect_blk(64'h8000000000000000, 1'b1, 32'd8);
        blk_readyxSI = 1'b0;
        for (int i = 0; i < 8; i++) put(8'h11 + 8'(i), 1'b1, 1'b0);
        msg_endxSI = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_data",  blk_dataxSO, 64'h1112131415161718);
            check("bp_valid", 64'(blk_validxSO), 64'd1);
            check("bp_ready", 64'(byte_readyxSO), 64'd0);
            @(posedge clk);
            #1;
        end
        blk_readyxSI = 1'b1;
        put(8'h00, 1'b0, 1'b1);
        drain();
        expect_blk(64'h4180000000000000, 1'b1, 32'd1);
        put(8'h41, 1'b1, 1'b1);
        drain();

        // Reset mid-message discards the partial block.
        for (int i = 0; i < 5; i++) put(8'hC0 + 8'(i), 1'b1, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_byte_ready", 64'(byte_readyxSO), 64'd1);
        check("mid_rst_blk_valid",  64'(blk_validxSO),  64'd0);
        check("mid_rst_blk_data",   blk_dataxSO,        64'd0);
        check("mid_rst_blk_last",   64'(blk_lastxSO),   64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expect_blk(64'hAA80000000000000, 1'b1, 32'd1);
        put(8'hAA, 1'b1, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
